datamem_sync: RTL and testbench
===============================

Name: datamem_sync

Overview:
Clocked, parametrised successor to the 16-bit asynchronous-strobe data memory. It is a single-port synchronous RAM with a request/valid handshake, byte-lane write enables and out-of-range address detection. It also has a hardware clear engine that zeroes the whole array over DEPTH cycles. It sits behind the datapath load/store unit and replaces the edge-triggered datamem.

Parameters:
DATA_W, 16, data word width in bits; must be a multiple of 8
ADDR_W, 16, address bus width in bits (word addressing)
DEPTH, 1024, number of words implemented; DEPTH <= 2**ADDR_W
BE_W, DATA_W/8, number of byte lanes (derived, not overridden)

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  asynchronous active-high reset
req  in  1  access request, sampled each rising edge when busy=0
we_DM  in  1  1 = write, 0 = read; qualified by req
be  in  BE_W  byte-lane write enables; bit i covers dataDM[8i+7:8i]; ignored on reads
addrDM  in  ADDR_W  word address
dataDM  in  DATA_W  write data
clr_start  in  1  one-cycle pulse that starts a full-array clear
outDM  out  DATA_W  read data, valid when rvalid=1
rvalid  out  1  one-cycle pulse marking outDM valid
err  out  1  one-cycle pulse: the access accepted on the previous edge was out of range
busy  out  1  clear in progress; req is ignored while high

Behaviour:
- Reset (async assert, sync release): outDM=0, rvalid=0, err=0, busy=0, state=IDLE, clear counter=0. RAM contents are not reset.
- Acceptance:
  - A request is accepted on a rising edge with req=1 and busy=0.
  - One access per cycle. Back-to-back accesses on consecutive cycles are supported with no bubbles.
- Write:
  - Accepted write with addrDM < DEPTH updates mem[addrDM] at that edge, for enabled lanes only. Disabled lanes are unchanged.
  - be=0 is a legal no-op write.
  - No rvalid on writes.
- Read:
  - Latency is 1 cycle. A read accepted at edge N drives outDM=mem[addrDM] and rvalid=1 during cycle N..N+1 (registered output).
  - outDM holds its last value when rvalid=0.
- Ordering: a read accepted the edge after a write to the same address returns the new data. There is no read-during-write case, since there is a single port.
- Out of range (addrDM >= DEPTH):
  - Writes are dropped; memory is unchanged.
  - Reads drive outDM=0 with rvalid=1.
  - Both raise err=1 for one cycle, aligned with where rvalid would be.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start=1, sampled on the edge. busy=1 from the next cycle.
  - A clr_start coinciding with an accepted req: the req is serviced on that edge and the clear starts on the same edge.
  - CLEAR: writes mem[cnt]=0 and increments cnt each cycle.
  - On cnt=DEPTH-1, the final word is written, then return to IDLE with cnt=0 and busy=0. busy is high for exactly DEPTH cycles.
  - clr_start during CLEAR is ignored (no restart).
- Reset mid-clear: returns to IDLE immediately. Contents are partially cleared; words not yet cleared retain old values.
- Widths:
  - Address compare is an unsigned ADDR_W-bit comparison.
  - The clear counter is clog2(DEPTH) bits; if DEPTH is a power of 2 it wraps naturally at the end of CLEAR.
- rvalid and err never both assert for an in-range read. Both are 0 in every cycle with no accepted access.

Test Plan:
1. Reset with rst=1 mid-sim -> outDM=0, rvalid=0, err=0, busy=0 immediately, before the next clk edge.
2. Write 16'h1dfe to addr 0 (be=2'b11), then read addr 0 the next cycle -> rvalid=1 one cycle after the read, outDM=16'h1dfe.
3. Write 16'hFFFF to addr 5, write 16'h1234 with be=2'b01, read 5 -> outDM=16'hFF34.
4. Back-to-back: write addr 1=16'h1001, write addr 2=16'ha001, read 1, read 2 on consecutive edges -> outDM=16'h1001 then 16'ha001 on consecutive cycles, rvalid high for 2 cycles.
5. Out of range: write addr 1024 data 16'hBEEF, then read 1024 -> err pulses twice, outDM=0 for the read, and a read of addr 0 (1024 mod 1024) still returns the prior 16'h1dfe.
6. Clear: fill addrs 0-3, pulse clr_start -> busy high exactly 1024 cycles and req ignored meanwhile, then reads of 0-3 return 0. Repeat with rst asserted after 10 clear cycles -> busy=0 at once, addrs 0-9 read 0, addr 10+ retain data.

Source files
------------

// File: rtl/datamem_sync.sv
// Single-port synchronous data RAM: request handshake, byte-lane writes,
// out-of-range detection and a hardware engine that zeroes the whole array.
// Reads have 1-cycle latency (registered outDM/rvalid). While busy (clear
// running) requests are ignored and the requester must hold off.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   req, we_DM  : access request and write/read select
//   be          : byte-lane write enables (writes only)
//   addrDM      : word address; dataDM : write data
//   clr_start   : pulse that starts a full-array clear
//   outDM       : read data, valid with rvalid
//   rvalid, err : read-valid pulse, out-of-range pulse
//   busy        : clear in progress
module datamem_sync #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we_DM,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addrDM,
  input  logic [DATA_W-1:0]     dataDM,
  input  logic                  clr_start,
  output logic [DATA_W-1:0]     outDM,
  output logic                  rvalid,
  output logic                  err,
  output logic                  busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [CNT_W-1:0]  idx;

  assign accept   = req && (state_q == IDLE);
  assign in_range = {1'b0, addrDM} < DEPTH_A;
  assign idx      = addrDM[CNT_W-1:0];

  // Clear engine: next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // Explicit return to 0 so non-power-of-2 depths end cleanly too.
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Read response path: registered data, valid and error pulses.
  always_comb begin
    rvalid_d = accept && !we_DM;
    err_d    = accept && !in_range;
    out_d    = out_q;
    if (accept && !we_DM) begin
      out_d = in_range ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      out_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset. Clear writes and user writes never coincide:
  // user accesses are only accepted in IDLE.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (accept && we_DM && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= dataDM[8*i +: 8];
        end
      end
    end
  end

  assign outDM  = out_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign busy   = (state_q == CLEAR);

endmodule

// File: tb/tb_datamem_sync.sv
module tb_datamem_sync;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we_DM;
  logic [1:0]  be;
  logic [15:0] addrDM;
  logic [15:0] dataDM;
  logic        clr_start;
  logic [15:0] outDM;
  logic        rvalid;
  logic        err;
  logic        busy;

  datamem_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .we_DM(we_DM), .be(be),
    .addrDM(addrDM), .dataDM(dataDM), .clr_start(clr_start),
    .outDM(outDM), .rvalid(rvalid), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          rv;
    bit          er;
    logic [15:0] dat;
  } exp_t;

  // Reference model state
  logic [15:0] ref_mem [DEPTH];
  exp_t        exp_q [$];
  bit          clr_active;
  int          clr_e;
  int          cyc;
  bit          rst_active;

  int n_checks;
  int n_errors;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit mbusy(input int e);
    return clr_active && (e > clr_e) && (e <= clr_e + DEPTH);
  endfunction

  // Apply a finished clear to the model once it is fully in the past.
  function automatic void settle(input int e);
    if (clr_active && e > clr_e + DEPTH) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      clr_active = 1'b0;
    end
  endfunction

  // Drive one cycle of stimulus and update the model for the coming edge.
  task automatic op(input bit rq, input bit w, input logic [1:0] b,
                    input logic [15:0] a, input logic [15:0] d, input bit c);
    int   en;
    exp_t x;
    @(negedge clk);
    req = rq; we_DM = w; be = b; addrDM = a; dataDM = d; clr_start = c;
    en = cyc + 1;
    settle(en);
    if (rq && !mbusy(en)) begin
      x.due = en;
      x.rv  = !w;
      x.er  = (a >= DEPTH);
      x.dat = '0;
      if (a < DEPTH) begin
        if (w) begin
          for (int i = 0; i < 2; i++)
            if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        end else begin
          x.dat = ref_mem[a];
        end
      end
      if (!w || a >= DEPTH) exp_q.push_back(x);
    end
    if (c && !mbusy(en)) begin
      clr_active = 1'b1;
      clr_e      = en;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
    op(1'b1, 1'b1, b, a, d, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a);
    op(1'b1, 1'b0, 2'b00, a, 16'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
  endtask

  // Random traffic (including clr_start pulses) while a clear is running.
  task automatic noise(input int n);
    for (int i = 0; i < n; i++)
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
         16'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 3) == 0));
  endtask

  // Asynchronous reset mid-cycle; outputs must drop before the next edge.
  task automatic do_reset();
    int n;
    @(posedge clk);
    #2;
    rst = 1'b1; rst_active = 1'b1;
    req = 1'b0; clr_start = 1'b0;
    #1;
    chk("rst_outDM",  32'(outDM),  32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_err",    32'(err),    32'h0);
    chk("rst_busy",   32'(busy),   32'h0);
    if (clr_active) begin
      n = cyc - clr_e;
      if (n > DEPTH) n = DEPTH;
      for (int i = 0; i < n; i++) ref_mem[i] = '0;
      clr_active = 1'b0;
    end
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0; rst_active = 1'b0;
  endtask

  // Monitor: compares every cycle against the scoreboard.
  exp_t mon_cur;
  bit   mon_have;
  always @(negedge clk) begin
    if (!rst_active) begin
      mon_have = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        mon_cur = exp_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missed_response: expected at cycle %0d", mon_cur.due);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_cur  = exp_q.pop_front();
        mon_have = 1'b1;
      end
      chk("rvalid", 32'(rvalid), mon_have ? 32'(mon_cur.rv) : 32'h0);
      chk("err",    32'(err),    mon_have ? 32'(mon_cur.er) : 32'h0);
      if (mon_have && mon_cur.rv) chk("outDM", 32'(outDM), 32'(mon_cur.dat));
      chk("busy", 32'(busy),
          32'(clr_active && (cyc >= clr_e) && (cyc < clr_e + DEPTH)));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    clr_active = 1'b0; clr_e = 0; rst_active = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    req = 0; we_DM = 0; be = 0; addrDM = 0; dataDM = 0; clr_start = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("init_outDM",  32'(outDM),  32'h0);
    chk("init_rvalid", 32'(rvalid), 32'h0);
    chk("init_err",    32'(err),    32'h0);
    chk("init_busy",   32'(busy),   32'h0);
    @(posedge clk); @(posedge clk);
    #2;
    rst = 1'b0; rst_active = 1'b0;

    // Bring the array to a known state with the clear engine.
    op(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b1);
    noise(DEPTH);
    idle(2);

    // Write then read back next cycle.
    wr(16'd0, 16'h1dfe, 2'b11);
    rd(16'd0);

    // Byte-lane merge.
    wr(16'd5, 16'hFFFF, 2'b11);
    wr(16'd5, 16'h1234, 2'b01);
    rd(16'd5);
    wr(16'd6, 16'hABCD, 2'b11);
    wr(16'd6, 16'h5555, 2'b00);
    wr(16'd6, 16'h9900, 2'b10);
    rd(16'd6);

    // Back-to-back with no bubbles.
    wr(16'd1, 16'h1001, 2'b11);
    wr(16'd2, 16'ha001, 2'b11);
    rd(16'd1);
    rd(16'd2);

    // Out of range: no aliasing onto word 0.
    wr(16'd1024, 16'hBEEF, 2'b11);
    rd(16'd1024);
    rd(16'hFFFF);
    rd(16'd1023);
    rd(16'd0);
    idle(2);

    // Asynchronous reset right after a read is accepted; RAM keeps contents.
    rd(16'd5);
    do_reset();
    rd(16'd5);
    idle(2);

    // Full clear with random requests ignored while busy.
    for (int i = 0; i < 4; i++) wr(16'(i), 16'($urandom_range(1, 65535)), 2'b11);
    op(1'b1, 1'b0, 2'b00, 16'd3, 16'h0, 1'b1);
    noise(DEPTH);
    for (int i = 0; i < 4; i++) rd(16'(i));
    idle(2);

    // Reset after 10 clear cycles: only words 0..9 are zeroed.
    for (int i = 0; i < 16; i++) wr(16'(i), 16'($urandom_range(1, 65535)), 2'b11);
    op(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b1);
    idle(10);
    do_reset();
    for (int i = 0; i < 16; i++) rd(16'(i));
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1024, 65535))
                                       : 16'($urandom_range(0, 31));
      op(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
         2'($urandom_range(0, 3)), a, 16'($urandom), 1'b0);
    end
    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
